// File: rtl/smol_dbus.sv
// smol_dbus: CPU data-bus controller. Decodes ROM / DMEM / MMIO, drives DMEM
// write strobe, and issues a single-cycle completion pulse after a per-region latency.
module smol_dbus #(
    parameter int XLEN         = 32,
    parameter int ADDR_WIDTH   = 11,
    parameter int GPIO_WIDTH   = 8,
    parameter int RAM_SEL_BIT  = 9,
    parameter int MMIO_SEL_BIT = 12,
    parameter int ROM_LAT      = 1,
    parameter int RAM_LAT      = 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_loadReq,
    input  logic                  i_storeReq,
    input  logic [XLEN-1:0]       i_dataAddr,
    input  logic [XLEN-1:0]       i_dataOut,
    output logic [XLEN-1:0]       o_dataIn,
    output logic                  o_memValid,
    input  logic [XLEN-1:0]       i_romData,
    input  logic [XLEN-1:0]       i_ramData,
    output logic                  o_ramWe,
    output logic [ADDR_WIDTH-1:0] o_ramAddr,
    output logic [XLEN-1:0]       o_ramData,
    output logic [GPIO_WIDTH-1:0] o_gpio,
    input  logic [GPIO_WIDTH-1:0] i_gpio,
    output logic                  o_busErr
);

    // state | meaning
    // IDLE  | waiting; a pending request is accepted this cycle
    // BUSY  | counting down the region latency
    // VALID | o_memValid pulse
    // GAP   | one dead cycle so the CPU can drop its request
    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_VALID, S_GAP} state_t;
    typedef enum logic [1:0] {R_ROM, R_RAM, R_MMIO} region_t;

    localparam int CW = 8;
    localparam logic [XLEN-1:0] UNMAP_MASK =
        ((XLEN'(1) << MMIO_SEL_BIT) - XLEN'(1)) & ~XLEN'(15);

    state_t                state_q, state_d;
    region_t               region, region_q;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         lat_m1;
    logic [XLEN-1:0]       mmio_rd_q, mmio_rdata;
    logic [GPIO_WIDTH-1:0] gpio_q, gpio_s1, gpio_s2;
    logic [31:0]           cycle_q;
    logic [1:0]            err_q, err_d;
    logic                  accept, is_store, unmapped;
    logic [1:0]            mmio_off;

    // Gating with reset keeps the strobe quiet while requests are held in reset.
    assign accept   = (state_q == S_IDLE) && (i_loadReq || i_storeReq) && i_rst_n;
    assign is_store = i_storeReq;
    assign mmio_off = i_dataAddr[3:2];
    assign unmapped = |(i_dataAddr & UNMAP_MASK);

    always_comb begin
        region = R_ROM;
        lat_m1 = CW'(ROM_LAT - 1);
        if (i_dataAddr[MMIO_SEL_BIT]) begin
            region = R_MMIO;
            lat_m1 = '0;
        end else if (i_dataAddr[RAM_SEL_BIT]) begin
            region = R_RAM;
            lat_m1 = CW'(RAM_LAT - 1);
        end
    end

    always_comb begin
        mmio_rdata = '0;
        if (!unmapped) begin
            case (mmio_off)
                2'd0:    mmio_rdata = XLEN'(gpio_q);
                2'd1:    mmio_rdata = XLEN'(gpio_s2);
                2'd2:    mmio_rdata = XLEN'(cycle_q);
                default: mmio_rdata = XLEN'(err_q);
            endcase
        end
    end

    always_comb begin
        err_d = err_q;
        if (accept) begin
            if (is_store && region == R_MMIO && !unmapped && mmio_off == 2'd3)
                err_d = err_q & ~i_dataOut[1:0];
            if (is_store && region == R_ROM)
                err_d[0] = 1'b1;
            if (region == R_MMIO && unmapped)
                err_d[1] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = (lat_m1 == '0) ? S_VALID : S_BUSY;
            S_BUSY:  if (cnt_q == CW'(1)) state_d = S_VALID;
            S_VALID: state_d = S_GAP;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            region_q  <= R_ROM;
            cnt_q     <= '0;
            mmio_rd_q <= '0;
            gpio_q    <= '0;
            gpio_s1   <= '0;
            gpio_s2   <= '0;
            cycle_q   <= '0;
            err_q     <= '0;
        end else begin
            state_q <= state_d;
            gpio_s1 <= i_gpio;
            gpio_s2 <= gpio_s1;
            cycle_q <= cycle_q + 32'd1;
            err_q   <= err_d;
            if (accept) begin
                region_q  <= region;
                cnt_q     <= lat_m1;
                mmio_rd_q <= mmio_rdata;
                if (is_store && region == R_MMIO && !unmapped && mmio_off == 2'd0)
                    gpio_q <= i_dataOut[GPIO_WIDTH-1:0];
            end else if (state_q == S_BUSY) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

    always_comb begin
        o_dataIn = '0;
        if (state_q == S_VALID) begin
            case (region_q)
                R_ROM:   o_dataIn = i_romData;
                R_RAM:   o_dataIn = i_ramData;
                default: o_dataIn = mmio_rd_q;
            endcase
        end
    end

    assign o_memValid = (state_q == S_VALID);
    assign o_ramWe    = accept && is_store && (region == R_RAM);
    assign o_ramAddr  = i_dataAddr[ADDR_WIDTH-1:0];
    assign o_ramData  = i_dataOut;
    assign o_gpio     = gpio_q;
    assign o_busErr   = |err_q;

endmodule

// File: tb/tb_smol_dbus.sv
// Randomised scoreboard bench for smol_dbus with a behavioural bus model and
// simple ROM/BRAM stand-ins.
module tb_smol_dbus;

    localparam int ROM_LAT = 2;
    localparam int RAM_LAT = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_req, store_req;
    logic [31:0] addr, wdata, data_in;
    logic        mem_valid;
    logic [31:0] rom_data, ram_data;
    logic        ram_we;
    logic [10:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [7:0]  gpio_o, gpio_i;
    logic        bus_err;

    smol_dbus #(.ROM_LAT(ROM_LAT), .RAM_LAT(RAM_LAT)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_loadReq(load_req), .i_storeReq(store_req),
        .i_dataAddr(addr), .i_dataOut(wdata), .o_dataIn(data_in),
        .o_memValid(mem_valid), .i_romData(rom_data), .i_ramData(ram_data),
        .o_ramWe(ram_we), .o_ramAddr(ram_addr), .o_ramData(ram_wdata),
        .o_gpio(gpio_o), .i_gpio(gpio_i), .o_busErr(bus_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] rom_fn(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    logic [31:0] bram [512];
    always @(posedge clk) begin
        rom_data <= rom_fn(addr);
        if (ram_we) bram[ram_addr[10:2]] <= ram_wdata;
        ram_data <= bram[ram_addr[10:2]];
    end

    // Cycle index since reset release; equals the CYCLE register's value.
    logic [31:0] cyc;
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc = 0; else cyc = cyc + 1;

    typedef struct { logic chk; logic [31:0] data; logic [31:0] vcyc; } exp_t;
    typedef struct { logic [10:0] a; logic [31:0] d; logic [31:0] c; } we_t;
    exp_t sb[$];
    we_t  we_q[$];

    int n_chk = 0;
    int n_fail = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [7:0]  gpio_m, gpio_in_m;
    logic [1:0]  err_m;
    logic [31:0] mem_m [512];
    bit          wr_m  [512];

    always @(negedge rst_n) begin
        sb.delete();
        we_q.delete();
    end

    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        we_t  w;
        if (rst_n) begin
            if (mem_valid) begin
                check("valid_single", prev_valid, 0);
                check("valid_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("latency", cyc, e.vcyc);
                    if (e.chk) check("load_data", data_in, e.data);
                end
            end else begin
                check("data_idle_zero", data_in, 0);
            end
            if (ram_we) begin
                check("we_expected", we_q.size() != 0, 1);
                if (we_q.size() != 0) begin
                    w = we_q.pop_front();
                    check("we_addr", ram_addr, w.a);
                    check("we_data", ram_wdata, w.d);
                    check("we_cycle", cyc, w.c);
                end
            end
        end
        prev_valid = mem_valid;
    end

    // One CPU access: model the expected result, drive, wait for completion.
    task automatic do_access(input logic ld, input logic st, input logic [31:0] a,
                             input logic [31:0] d, input bit hold);
        exp_t e;
        we_t  w;
        int   lat;
        logic [8:0] idx;
        e.chk = 0;
        e.data = 0;
        if (a[12]) begin
            lat = 1;
            e.chk = !st;
            if (a[11:4] != 0) begin
                e.data = 0;
                err_m[1] = 1'b1;
            end else begin
                case (a[3:2])
                    2'd0: e.data = {24'd0, gpio_m};
                    2'd1: e.data = {24'd0, gpio_in_m};
                    2'd2: e.data = cyc;
                    default: e.data = {30'd0, err_m};
                endcase
                if (st && a[3:2] == 2'd0) gpio_m = d[7:0];
                if (st && a[3:2] == 2'd3) err_m = err_m & ~d[1:0];
            end
        end else if (a[9]) begin
            lat = RAM_LAT;
            idx = a[10:2];
            if (st) begin
                w.a = a[10:0]; w.d = d; w.c = cyc;
                we_q.push_back(w);
                mem_m[idx] = d;
                wr_m[idx] = 1;
            end else begin
                e.data = mem_m[idx];
                e.chk = wr_m[idx];
            end
        end else begin
            lat = ROM_LAT;
            if (st) err_m[0] = 1'b1;
            e.data = rom_fn(a);
            e.chk = !st;
        end
        e.vcyc = cyc + lat;
        sb.push_back(e);
        load_req = ld; store_req = st; addr = a; wdata = d;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (mem_valid) break;
        end
        check("valid_seen", mem_valid, 1);
        check("gpio_out", gpio_o, gpio_m);
        check("bus_err", bus_err, |err_m);
        @(posedge clk); #1;
        if (!hold) begin load_req = 0; store_req = 0; end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_valid", mem_valid, 0);
        check("rst_we", ram_we, 0);
        check("rst_gpio", gpio_o, 0);
        check("rst_buserr", bus_err, 0);
        check("rst_datain", data_in, 0);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] base;
        base = $urandom & 32'hFFFF_E000;
        case ($urandom_range(0, 4))
            0: return base | ($urandom & 32'h0DFC);
            1, 2: return base | 32'h200 | ($urandom & 32'h041C);
            3: return base | 32'h1000 | ($urandom & 32'h000F);
            default: return base | 32'h1000 | (32'($urandom_range(1, 255)) << 4) | ($urandom & 32'hF);
        endcase
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int op;
        for (int i = 0; i < 512; i++) wr_m[i] = 0;
        gpio_m = 0; gpio_in_m = 0; err_m = 0;
        gpio_i = 0;
        rst_n = 0;
        load_req = 1; store_req = 1; addr = 32'h200; wdata = 32'hFFFF_FFFF;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        load_req = 0; store_req = 0;
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;

        do_access(0, 1, 32'h200, 32'hDEADBEEF, 0);
        do_access(1, 0, 32'h200, 0, 0);
        do_access(0, 1, 32'h204, 32'h12345678, 1);
        do_access(0, 1, 32'h204, 32'h12345678, 0);
        do_access(1, 0, 32'h204, 0, 0);

        do_access(0, 1, 32'h3000, 32'h0000_00A5, 0);
        gpio_i = 8'h3C; gpio_in_m = 8'h3C;
        repeat (2) begin @(posedge clk); #1; end
        do_access(1, 0, 32'h3004, 0, 0);

        do_access(0, 1, 32'h0010, 32'hCAFE0000, 0);
        do_access(1, 0, 32'h300C, 0, 0);
        do_access(1, 0, 32'h3010, 0, 0);
        do_access(1, 0, 32'h300C, 0, 0);
        do_access(0, 1, 32'h300C, 32'h1, 0);
        do_access(1, 0, 32'h300C, 0, 0);
        do_access(0, 1, 32'h300C, 32'h2, 0);
        do_access(1, 0, 32'h300C, 0, 0);

        do_access(1, 0, 32'h3008, 0, 0);
        repeat (7) begin @(posedge clk); #1; end
        do_access(1, 0, 32'h3008, 0, 0);

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                gpio_i = 8'($urandom); gpio_in_m = gpio_i;
                repeat (2) begin @(posedge clk); #1; end
            end
            a = rand_addr();
            op = $urandom_range(0, 3);
            do_access(op < 2, op >= 2, a, $urandom, 0);
        end

        // Abort a DMEM access while it is counting down.
        load_req = 1; addr = 32'h208;
        @(posedge clk); #1;
        @(negedge clk) rst_n = 0;
        gpio_m = 0; err_m = 0;
        @(negedge clk);
        check_reset_outputs();
        load_req = 0;
        @(negedge clk) rst_n = 1;
        repeat (6) begin @(posedge clk); #1; end
        do_access(1, 0, 32'h200, 0, 0);
        do_access(1, 0, 32'h3008, 0, 0);

        check("sb_drained", sb.size(), 0);
        check("we_drained", we_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
